// File: rtl/axi_read_responder.sv
// AXI-style read responder: serves one AR request at a time with ARLENGTH+1 64-bit beats
// from a preloadable word memory, with optional fixed delay before the first beat.
module axi_read_responder #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned RESP_DELAY = 0
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLENGTH,
  input  logic [2:0]            ARSIZE,
  input  logic [1:0]            ARBURST,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [63:0]           RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-4:0] WADDR,
  input  logic [63:0]           WDATA
);

  localparam int unsigned WordW = ADDR_WIDTH - 3;
  localparam int unsigned Depth = 2 ** WordW;
  localparam logic [3:0]  DelayInit = 4'(RESP_DELAY);
  localparam logic [WordW-1:0] WordOne = {{(WordW-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

  state_e           state_q;
  logic             arready_q, rvalid_q, rlast_q;
  logic [1:0]       rresp_q;
  logic [63:0]      rdata_q;
  logic [WordW-1:0] word_q;
  logic [7:0]       cnt_q;
  logic [3:0]       dly_q;
  logic             fixed_q, err_q;

  logic [63:0] mem_q [Depth];

  // Memory is deliberately not reset so preloaded contents survive a reset.
  always_ff @(posedge CLK) begin
    if (WE) mem_q[WADDR] <= WDATA;
  end

  logic             ar_err;
  logic [WordW-1:0] ar_word, next_word, ld_word;
  logic             ld_err;
  logic [63:0]      ld_data;
  logic [1:0]       ld_resp;
  logic             unused_lsb;

  assign unused_lsb = ^ARADDR[2:0];
  assign ar_err     = (ARSIZE != 3'd3) | (ARBURST == 2'd3);
  assign ar_word    = ARADDR[ADDR_WIDTH-1:3];
  assign next_word  = fixed_q ? word_q : word_q + WordOne;

  // Source of the beat loaded at this edge: the new request in idle, else the latched burst.
  always_comb begin
    ld_word = word_q;
    ld_err  = err_q;
    if (state_q == StIdle) begin
      ld_word = ar_word;
      ld_err  = ar_err;
    end else if (state_q == StBurst) begin
      ld_word = next_word;
    end
    ld_data = ld_err ? 64'd0 : mem_q[ld_word];
    ld_resp = ld_err ? 2'd2 : 2'd0;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= StIdle;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= 2'd0;
      rdata_q   <= 64'd0;
      word_q    <= '0;
      cnt_q     <= 8'd0;
      dly_q     <= 4'd0;
      fixed_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ARVALID && arready_q) begin
            arready_q <= 1'b0;
            word_q    <= ar_word;
            cnt_q     <= ARLENGTH;
            fixed_q   <= (ARBURST == 2'd0);
            err_q     <= ar_err;
            if (RESP_DELAY == 0) begin
              state_q  <= StBurst;
              rvalid_q <= 1'b1;
              rdata_q  <= ld_data;
              rresp_q  <= ld_resp;
              rlast_q  <= (ARLENGTH == 8'd0);
            end else begin
              state_q <= StWait;
              dly_q   <= DelayInit;
            end
          end else begin
            arready_q <= 1'b1;
          end
        end
        StWait: begin
          if (dly_q == 4'd1) begin
            state_q  <= StBurst;
            rvalid_q <= 1'b1;
            rdata_q  <= ld_data;
            rresp_q  <= ld_resp;
            rlast_q  <= (cnt_q == 8'd0);
          end else begin
            dly_q <= dly_q - 4'd1;
          end
        end
        StBurst: begin
          if (RREADY) begin
            if (cnt_q == 8'd0) begin
              // RDATA intentionally holds the final beat.
              state_q   <= StIdle;
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              rresp_q   <= 2'd0;
              arready_q <= 1'b1;
            end else begin
              word_q  <= next_word;
              cnt_q   <= cnt_q - 8'd1;
              rdata_q <= ld_data;
              rresp_q <= ld_resp;
              rlast_q <= (cnt_q == 8'd1);
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axi_read_responder.sv
// Bench for axi_read_responder: two instances (RESP_DELAY 0 and 3) share preload and AR fields;
// each burst is checked beat by beat against an array model of memory and burst addressing.
module tb_axi_read_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  araddr, arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arvalid, rready, arready, rvalid, rlast;
  logic [63:0] rdata [2];
  logic [1:0]  rresp [2];
  logic        we;
  logic [4:0]  waddr;
  logic [63:0] wdata;

  logic [63:0] mem_m [32];
  logic [63:0] got_q [$];
  int n_checks = 0;
  int n_fail = 0;

  axi_read_responder #(.ADDR_WIDTH(8), .RESP_DELAY(0)) u_dut0 (
    .CLK(clk), .RESET_N(rst_n), .ARADDR(araddr), .ARLENGTH(arlen), .ARSIZE(arsize),
    .ARBURST(arburst), .ARVALID(arvalid[0]), .ARREADY(arready[0]), .RDATA(rdata[0]),
    .RRESP(rresp[0]), .RLAST(rlast[0]), .RVALID(rvalid[0]), .RREADY(rready[0]),
    .WE(we), .WADDR(waddr), .WDATA(wdata)
  );

  axi_read_responder #(.ADDR_WIDTH(8), .RESP_DELAY(3)) u_dut1 (
    .CLK(clk), .RESET_N(rst_n), .ARADDR(araddr), .ARLENGTH(arlen), .ARSIZE(arsize),
    .ARBURST(arburst), .ARVALID(arvalid[1]), .ARREADY(arready[1]), .RDATA(rdata[1]),
    .RRESP(rresp[1]), .RLAST(rlast[1]), .RVALID(rvalid[1]), .RREADY(rready[1]),
    .WE(we), .WADDR(waddr), .WDATA(wdata)
  );

  task automatic preload(input logic [4:0] a, input logic [63:0] d);
    we = 1'b1; waddr = a; wdata = d;
    @(negedge clk);
    we = 1'b0;
    mem_m[a] = d;
  endtask

  // mode: 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random ready.
  // we_beat >= 1: write we_word on the edge that loads beat we_beat.
  task automatic do_read(input int sel, input logic [7:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input int mode,
                         input int we_beat, input logic [4:0] we_word, input logic [63:0] we_val);
    int n, i, guard, d;
    logic r, err;
    logic [4:0] w;
    logic [63:0] ed, last_d;
    logic [3:0] pat;
    pat = 4'b1001;
    d = (sel == 0) ? 0 : 3;
    err = (size != 3'd3) || (burst == 2'd3);
    last_d = 64'd0;
    got_q.delete();
    n = 0;
    while (arready[sel] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    n_checks++;
    if (arready[sel] !== 1'b1) begin
      n_fail++; $display("FAIL arready_idle dut%0d: got %b want 1", sel, arready[sel]);
      return;
    end
    araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid[sel] = 1'b1;
    @(negedge clk);
    arvalid[sel] = 1'b0;
    araddr = $urandom; arlen = $urandom; arsize = $urandom; arburst = $urandom;
    n_checks++;
    if (arready[sel] !== 1'b0) begin
      n_fail++; $display("FAIL arready_clear dut%0d: got %b want 0", sel, arready[sel]);
    end
    n = 0;
    while (rvalid[sel] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    n_checks++;
    if (n != d) begin
      n_fail++; $display("FAIL latency dut%0d: got %0d extra cycles want %0d", sel, n, d);
      if (rvalid[sel] !== 1'b1) return;
    end
    i = 0; guard = 0;
    while (i <= int'(len) && guard < 3000) begin
      w  = (burst == 2'd0) ? addr[7:3] : 5'(int'(addr[7:3]) + i);
      ed = err ? 64'd0 : mem_m[w];
      n_checks++;
      if (rvalid[sel] !== 1'b1 || rdata[sel] !== ed || rresp[sel] !== (err ? 2'd2 : 2'd0) ||
          rlast[sel] !== (i == int'(len))) begin
        n_fail++;
        $display("FAIL beat dut%0d #%0d: got v=%b d=%h resp=%0d last=%b want v=1 d=%h resp=%0d last=%b",
                 sel, i, rvalid[sel], rdata[sel], rresp[sel], rlast[sel], ed, err ? 2 : 0,
                 i == int'(len));
        if (rvalid[sel] !== 1'b1) break;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = pat[guard % 4];
        default: r = 1'($urandom_range(0, 1));
      endcase
      rready[sel] = r;
      if (r && i == we_beat - 1) begin we = 1'b1; waddr = we_word; wdata = we_val; end
      if (r) begin got_q.push_back(rdata[sel]); last_d = rdata[sel]; end
      @(negedge clk);
      we = 1'b0;
      rready[sel] = 1'b0;
      if (r) i++;
      guard++;
    end
    n_checks++;
    if (i <= int'(len)) begin
      n_fail++; $display("FAIL burst_complete dut%0d: got %0d beats want %0d", sel, i, len + 1);
      return;
    end
    n_checks++;
    if (rvalid[sel] !== 1'b0 || rlast[sel] !== 1'b0 || rresp[sel] !== 2'd0 ||
        arready[sel] !== 1'b1 || rdata[sel] !== last_d) begin
      n_fail++;
      $display("FAIL burst_end dut%0d: got v=%b last=%b resp=%0d ar=%b d=%h want 0 0 0 1 %h",
               sel, rvalid[sel], rlast[sel], rresp[sel], arready[sel], rdata[sel], last_d);
    end
    if (we_beat >= 1) mem_m[we_word] = we_val;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      n_checks++;
      if (arready[s] !== 1'b0 || rvalid[s] !== 1'b0 || rlast[s] !== 1'b0 ||
          rresp[s] !== 2'd0 || rdata[s] !== 64'd0) begin
        n_fail++;
        $display("FAIL reset_values dut%0d: got ar=%b v=%b last=%b resp=%0d d=%h want all 0",
                 s, arready[s], rvalid[s], rlast[s], rresp[s], rdata[s]);
      end
    end
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (arready !== 2'b00) begin
      n_fail++; $display("FAIL arready_before_edge: got %b want 00", arready);
    end
    @(negedge clk);
    n_checks++;
    if (arready !== 2'b11) begin
      n_fail++; $display("FAIL arready_after_reset: got %b want 11", arready);
    end
  endtask

  task automatic test_preload();
    for (int k = 0; k < 32; k++) preload(5'(k), 64'(k) * 64'h0101010101010101);
  endtask

  task automatic test_incr_and_stall();
    do_read(0, 8'h80, 8'd15, 3'd3, 2'd1, 0, -1, 5'd0, 64'd0);
    do_read(1, 8'h80, 8'd15, 3'd3, 2'd1, 1, -1, 5'd0, 64'd0);
  endtask

  task automatic test_wrap_and_fixed();
    do_read(0, 8'hF0, 8'd3, 3'd3, 2'd1, 0, -1, 5'd0, 64'd0);
    do_read(0, 8'h08, 8'd2, 3'd3, 2'd0, 0, -1, 5'd0, 64'd0);
    do_read(1, 8'hFD, 8'd2, 3'd3, 2'd2, 2, -1, 5'd0, 64'd0);
  endtask

  task automatic test_errors();
    do_read(0, 8'h00, 8'd1, 3'd2, 2'd1, 0, -1, 5'd0, 64'd0);
    do_read(0, 8'h18, 8'd0, 3'd3, 2'd1, 0, -1, 5'd0, 64'd0);
    do_read(1, 8'h20, 8'd2, 3'd3, 2'd3, 1, -1, 5'd0, 64'd0);
  endtask

  task automatic test_midburst_write();
    do_read(0, 8'h00, 8'd7, 3'd3, 2'd1, 0, 5, 5'd5, 64'hDEAD_BEEF_0BAD_F00D);
    do_read(0, 8'h28, 8'd0, 3'd3, 2'd1, 0, -1, 5'd0, 64'd0);
  endtask

  task automatic test_len255();
    do_read(1, 8'h38, 8'd255, 3'd3, 2'd1, 2, -1, 5'd0, 64'd0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 14; t++) begin
      if ($urandom_range(0, 1) == 1) preload(5'($urandom), {$urandom, $urandom});
      do_read($urandom_range(0, 1), 8'($urandom), 8'($urandom_range(0, 20)),
              ($urandom_range(0, 6) == 0) ? 3'($urandom_range(0, 2)) : 3'd3,
              2'($urandom_range(0, 3)), 2, -1, 5'd0, 64'd0);
    end
  endtask

  task automatic test_reset_mid_burst();
    araddr = 8'h40; arlen = 8'd15; arsize = 3'd3; arburst = 2'd1; arvalid[0] = 1'b1;
    @(negedge clk);
    arvalid[0] = 1'b0;
    rready[0] = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (rvalid[0] !== 1'b0 || arready[0] !== 1'b0 || rlast[0] !== 1'b0 || rdata[0] !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_abort: got v=%b ar=%b last=%b d=%h want 0 0 0 0",
               rvalid[0], arready[0], rlast[0], rdata[0]);
    end
    rready[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (arready[0] !== 1'b1 || rvalid[0] !== 1'b0) begin
      n_fail++; $display("FAIL reset_release: got ar=%b v=%b want 1 0", arready[0], rvalid[0]);
    end
    do_read(0, 8'h40, 8'd15, 3'd3, 2'd1, 0, -1, 5'd0, 64'd0);
  endtask

  // Two 128-byte bursts as a 128x2 frame would issue them: 0x80, then 0x100 wrapping to 0x00.
  task automatic test_dma_stream();
    logic [7:0] bytes_q [$];
    logic [7:0] a;
    logic [63:0] wd;
    for (int b = 0; b < 2; b++) begin
      do_read(0, (b == 0) ? 8'h80 : 8'h00, 8'd15, 3'd3, 2'd1, 0, -1, 5'd0, 64'd0);
      foreach (got_q[j]) for (int k = 0; k < 8; k++) bytes_q.push_back(got_q[j][8*k +: 8]);
    end
    n_checks++;
    if (bytes_q.size() != 256) begin
      n_fail++; $display("FAIL dma_bytes: got %0d bytes want 256", bytes_q.size());
    end else begin
      for (int b = 0; b < 256; b++) begin
        a  = 8'(128 + b);
        wd = mem_m[a[7:3]];
        n_checks++;
        if (bytes_q[b] !== wd[8*a[2:0] +: 8]) begin
          n_fail++; $display("FAIL dma_byte %0d: got %h want %h", b, bytes_q[b], wd[8*a[2:0] +: 8]);
        end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; arvalid = 2'b00; rready = 2'b00; we = 1'b0; waddr = 5'd0; wdata = 64'd0;
    araddr = 8'd0; arlen = 8'd0; arsize = 3'd3; arburst = 2'd1;
    test_reset();
    test_preload();
    test_incr_and_stall();
    test_wrap_and_fixed();
    test_errors();
    test_midburst_write();
    test_len255();
    test_random();
    test_reset_mid_burst();
    test_dma_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axi_read_responder.md
# axi_read_responder

AXI-style read-channel responder: the memory-side slave that serves the `dma` block's AR/R transactions.
- Accepts one read-address request at a time and returns `ARLENGTH+1` 64-bit data beats from an internal word memory.
- Memory is preloaded through a simple write port.
- Used as the memory model under the camera DMA, and as the on-chip frame buffer in small integrations.

## Interface
Parameters:
- `ADDR_WIDTH`, default 8: byte-address width. Memory depth is `2**(ADDR_WIDTH-3)` 64-bit words (32 at default).
- `RESP_DELAY`, default 0: idle cycles between AR handshake and first RVALID; legal range 0–15.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: clock, all state on rising edge.
- `RESET_N` in 1: asynchronous active-low reset.
- `ARADDR` in ADDR_WIDTH: byte start address.
- `ARLENGTH` in 8: beats minus one.
- `ARSIZE` in 3: beat size code; only 3 (8 bytes) is legal.
- `ARBURST` in 2: 0 = FIXED, 1 = INCR, 2 = WRAP (treated as INCR), 3 = reserved.
- `ARVALID` in 1: request valid.
- `ARREADY` out 1: request accepted when high together with ARVALID.
- `RDATA` out 64: beat data.
- `RRESP` out 2: 0 = OKAY, 2 = SLVERR.
- `RLAST` out 1: final beat of burst.
- `RVALID` out 1: beat valid.
- `RREADY` in 1: beat consumed when high together with RVALID.
- `WE` in 1: preload write enable.
- `WADDR` in ADDR_WIDTH-3: preload word index.
- `WDATA` in 64: preload data.

## Operation
- States:
  - IDLE: ARREADY=1.
  - WAIT: delay counter running.
  - BURST: RVALID=1.
- AR handshake (ARVALID & ARREADY at an edge):
  - Latches aligned word address `ARADDR[ADDR_WIDTH-1:3]` (low 3 bits ignored), beat counter = ARLENGTH, burst type, error flag.
  - Clears ARREADY.
  - With RESP_DELAY=0, goes to BURST and loads RDATA/RRESP/RLAST for beat 0 at the same edge; otherwise goes to WAIT with counter = RESP_DELAY.
- WAIT: decrement each cycle. The edge at which the counter is 1 loads beat 0 and enters BURST.
- Error flag = (ARSIZE != 3) | (ARBURST == 3).
  - Error bursts still return all ARLENGTH+1 beats, with RDATA=0 and RRESP=2.
  - Otherwise RRESP=0 and RDATA = mem[word].
- Beat handshake (RVALID & RREADY at an edge):
  - Not last beat: advance word (INCR/WRAP: +1 modulo depth, so address wraps 0xF8→0x00; FIXED: unchanged), decrement counter, load next RDATA/RRESP. RLAST=1 when the new counter is 0.
  - Last beat: RVALID=0, RLAST=0, RRESP=0, RDATA holds its value, ARREADY=1, return to IDLE.
- While RVALID=1 and RREADY=0, RDATA/RRESP/RLAST hold stable; no timeout.
- ARVALID is ignored outside IDLE; no queueing.
- Preload: WE writes mem[WADDR] at the edge, in any state.
  - A same-edge write to the word being loaded into RDATA yields the old value; the new value is visible to later loads.
- Memory contents are not reset.

## Timing
- Reset values while RESET_N=0: ARREADY=0, RVALID=0, RLAST=0, RRESP=0, RDATA=0, state IDLE.
- ARREADY rises at the first rising edge after RESET_N deasserts.
- Reset mid-burst aborts immediately (asynchronous); the burst is not resumed.
- Latency: the first beat is visible 1+RESP_DELAY cycles after the AR handshake edge.
- Throughput: one beat per cycle while RREADY=1.
- After the last beat handshake, ARREADY=1 the next cycle; minimum 1 idle cycle between bursts.
- ARLENGTH=0 gives a single beat with RLAST=1.
- ARLENGTH=255 gives 256 beats; the 8-bit counter never underflows.

## Test plan
- Preload mem[k]=k*0x0101010101010101 (k=0..31). AR addr 0x80, len 15, size 3, burst 1, RESP_DELAY=0, RREADY=1 -> RVALID high the cycle after handshake; 16 consecutive beats with data k=16..31; RLAST only on beat 16; RRESP=0; ARREADY back to 1 the following cycle.
- Same read with RREADY toggled 1,0,0,1 and RESP_DELAY=3 -> first RVALID 4 cycles after handshake; RDATA/RLAST stable across stalls; no beat skipped or duplicated.
- AR addr 0xF0, len 3, INCR -> words 30, 31, 0, 1 (address wrap). FIXED burst addr 0x08, len 2 -> word 1 returned three times.
- ARSIZE=2, len 1 -> two beats, RDATA=0, RRESP=2, RLAST on beat 2. Then a legal len-0 read -> single beat, RRESP=0, RLAST=1.
- Mid-burst checks:
  - WE to word 5 on the edge beat 5 loads -> old value returned. A repeat read returns the new value.
  - Assert RESET_N=0 mid-burst -> RVALID/ARREADY/RLAST drop at once. After release, ARREADY=1 and preloaded memory is intact.
- Drive the `dma` block with start_pulse, width 128, height 2 -> 2 bursts at 0x80 and 0x00 (wraps at 8 bits); 256 bytes streamed out in little-endian byte order of each word.
